// File: rtl/div_clk_monitor_pkg.sv
// Shared types for the divided-clock monitor: per-channel FSM states and the
// lock-run counter width.
package div_mon_pkg;

  typedef enum logic [1:0] {IDLE, FIRST, TRACK} state_e;

  localparam int MATCH_W = 4;

  // Saturating increment used by the match-run counter.
  function automatic logic [MATCH_W-1:0] sat_inc(input logic [MATCH_W-1:0] v,
                                                  input logic [MATCH_W-1:0] lim);
    return (v >= lim) ? lim : v + MATCH_W'(1);
  endfunction

endpackage

// File: rtl/div_clk_monitor_if.sv
// Bundle of divided-clock inputs and per-channel monitor results.
interface div_clk_monitor_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]       div_in;
  logic [N_CH-1:0]       rise_pulse;
  logic [N_CH-1:0]       fall_pulse;
  logic [N_CH*CNT_W-1:0] period;
  logic [N_CH-1:0]       period_valid;
  logic [N_CH-1:0]       locked;
  logic [N_CH-1:0]       timeout;

  modport master (
    output div_in,
    input  rise_pulse, fall_pulse, period, period_valid, locked, timeout
  );

  modport slave (
    input  div_in,
    output rise_pulse, fall_pulse, period, period_valid, locked, timeout
  );
endinterface

// File: rtl/div_clk_monitor_chan.sv
// One monitored channel: edge strobes, period measurement, lock tracking and
// sticky timeout, all in the source clock domain.
module div_chan_monitor
  import div_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [MATCH_W-1:0] LOCK_LIM = MATCH_W'(LOCK_COUNT);

  state_e             state, state_n;
  logic               div_q;
  logic               rise, fall;
  logic [CNT_W-1:0]   cnt, cnt_n, period_n;
  logic [MATCH_W-1:0] match_cnt, match_n;
  logic               pv_n, locked_n, timeout_n;

  assign rise = div_in & ~div_q;
  assign fall = ~div_in & div_q;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    period_n  = period;
    match_n   = match_cnt;
    pv_n      = 1'b0;
    timeout_n = timeout;
    // Lock follows a completed match run by one cycle; clears below win.
    locked_n  = locked | (match_cnt == LOCK_LIM);
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = FIRST;
          cnt_n   = CNT_W'(1);
        end
      end
      FIRST, TRACK: begin
        if (rise) begin
          // A rise on the terminal count is still a valid period.
          period_n = cnt;
          pv_n     = 1'b1;
          cnt_n    = CNT_W'(1);
          state_n  = TRACK;
          if (state == FIRST) begin
            match_n = '0;
          end else if (cnt == period) begin
            match_n = sat_inc(match_cnt, LOCK_LIM);
          end else begin
            match_n  = '0;
            locked_n = 1'b0;
          end
        end else if (cnt == CNT_MAX) begin
          state_n   = IDLE;
          cnt_n     = '0;
          match_n   = '0;
          locked_n  = 1'b0;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Track the input through reset so release does not fake an edge.
      div_q        <= div_in;
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      match_cnt    <= '0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      div_q        <= div_in;
      state        <= state_n;
      cnt          <= cnt_n;
      period       <= period_n;
      match_cnt    <= match_n;
      rise_pulse   <= rise;
      fall_pulse   <= fall;
      period_valid <= pv_n;
      locked       <= locked_n;
      timeout      <= timeout_n;
    end
  end

endmodule

// File: rtl/div_clk_monitor.sv
// Multi-channel divided-clock monitor: an array of independent channel
// monitors whose period registers are packed onto one output bus.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input logic               clk,
  input logic               rst,
  div_clk_monitor_if.slave  bus
);

  logic [N_CH-1:0]            rise_v, fall_v, pv_v, locked_v, timeout_v;
  logic [N_CH-1:0][CNT_W-1:0] period_ch;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    div_chan_monitor #(
      .CNT_W      (CNT_W),
      .LOCK_COUNT (LOCK_COUNT)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .div_in       (bus.div_in[i]),
      .rise_pulse   (rise_v[i]),
      .fall_pulse   (fall_v[i]),
      .period       (period_ch[i]),
      .period_valid (pv_v[i]),
      .locked       (locked_v[i]),
      .timeout      (timeout_v[i])
    );
  end

  // Packed layout puts channel i at [i*CNT_W +: CNT_W].
  assign bus.period       = period_ch;
  assign bus.rise_pulse   = rise_v;
  assign bus.fall_pulse   = fall_v;
  assign bus.period_valid = pv_v;
  assign bus.locked       = locked_v;
  assign bus.timeout      = timeout_v;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: two instances (8-bit and 4-bit period counters)
// share one stimulus and are compared each cycle against a timestamp model.
module tb_div_clk_monitor;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] din;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  div_clk_monitor_if #(.N_CH(2), .CNT_W(8)) bus8 ();
  div_clk_monitor_if #(.N_CH(2), .CNT_W(4)) bus4 ();

  div_clk_monitor #(.N_CH(2), .CNT_W(8), .LOCK_COUNT(LOCK)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8));
  div_clk_monitor #(.N_CH(2), .CNT_W(4), .LOCK_COUNT(LOCK)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4));

  // Waveform generator: per-channel high/low lengths, optional freeze.
  int hi[2], lo[2], run[2];
  bit lvl[2], frz[2];

  // Reference model, index [dut][ch]; dut 0 has CNT_W=8, dut 1 CNT_W=4.
  // Periods come from rise timestamps rather than a running counter.
  int cyc = 0;
  bit m_prev[2][2], m_arm[2][2], m_hp[2][2], m_due[2][2];
  bit m_lk[2][2], m_to[2][2], m_r[2][2], m_f[2][2], m_pv[2][2];
  int m_t[2][2], m_per[2][2], m_mc[2][2];

  task automatic model_step(input logic [1:0] v);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        int mx, el;
        bit r, nl;
        mx = (d == 0) ? 255 : 15;
        if (rst) begin
          m_prev[d][c] = v[c]; m_arm[d][c] = 0; m_hp[d][c] = 0; m_due[d][c] = 0;
          m_lk[d][c] = 0; m_to[d][c] = 0; m_r[d][c] = 0; m_f[d][c] = 0;
          m_pv[d][c] = 0; m_per[d][c] = 0; m_mc[d][c] = 0;
        end else begin
          r = v[c] && !m_prev[d][c];
          m_f[d][c] = !v[c] && m_prev[d][c];
          m_r[d][c] = r;
          m_prev[d][c] = v[c];
          m_pv[d][c] = 0;
          nl = m_lk[d][c] || m_due[d][c];
          el = cyc - m_t[d][c];
          if (m_arm[d][c] && r) begin
            if (m_hp[d][c]) begin
              if (el == m_per[d][c]) m_mc[d][c] = (m_mc[d][c] < LOCK) ? m_mc[d][c] + 1 : LOCK;
              else begin m_mc[d][c] = 0; nl = 0; end
            end else begin
              m_mc[d][c] = 0; m_hp[d][c] = 1;
            end
            m_per[d][c] = el; m_pv[d][c] = 1; m_t[d][c] = cyc;
          end else if (m_arm[d][c] && el == mx) begin
            m_arm[d][c] = 0; m_mc[d][c] = 0; nl = 0; m_to[d][c] = 1;
          end else if (!m_arm[d][c] && r) begin
            m_arm[d][c] = 1; m_t[d][c] = cyc; m_hp[d][c] = 0;
          end
          m_lk[d][c] = nl;
          m_due[d][c] = (m_mc[d][c] == LOCK);
        end
      end
    end
    cyc++;
  endtask

  function automatic logic [25:0] act8();
    return {bus8.rise_pulse, bus8.fall_pulse, bus8.period_valid, bus8.locked,
            bus8.timeout, bus8.period};
  endfunction
  function automatic logic [17:0] act4();
    return {bus4.rise_pulse, bus4.fall_pulse, bus4.period_valid, bus4.locked,
            bus4.timeout, bus4.period};
  endfunction
  function automatic logic [25:0] exp8();
    return {m_r[0][1], m_r[0][0], m_f[0][1], m_f[0][0], m_pv[0][1], m_pv[0][0],
            m_lk[0][1], m_lk[0][0], m_to[0][1], m_to[0][0],
            8'(m_per[0][1]), 8'(m_per[0][0])};
  endfunction
  function automatic logic [17:0] exp4();
    return {m_r[1][1], m_r[1][0], m_f[1][1], m_f[1][0], m_pv[1][1], m_pv[1][0],
            m_lk[1][1], m_lk[1][0], m_to[1][1], m_to[1][0],
            4'(m_per[1][1]), 4'(m_per[1][0])};
  endfunction

  // Present one stimulus value, clock it, advance the model, settle.
  task automatic gen_adv();
    for (int c = 0; c < 2; c++) begin
      if (!frz[c]) begin
        run[c]++;
        if (lvl[c] && run[c] >= hi[c]) begin lvl[c] = 0; run[c] = 0; end
        else if (!lvl[c] && run[c] >= lo[c]) begin lvl[c] = 1; run[c] = 0; end
      end
    end
    din = {lvl[1], lvl[0]};
    bus8.div_in = din;
    bus4.div_in = din;
    @(posedge clk);
    model_step(din);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; frz[0] = 1; frz[1] = 1; lvl[0] = 1; lvl[1] = 1; run[0] = 0; run[1] = 0;
    for (int k = 0; k < 3; k++) begin
      gen_adv();
      checks += 2;
      if (act8() !== '0) begin errors++; $display("FAIL rst_hold8 got %h exp 0", act8()); end
      if (act4() !== '0) begin errors++; $display("FAIL rst_hold4 got %h exp 0", act4()); end
    end
    rst = 0;
    for (int k = 0; k < 10; k++) begin
      gen_adv();
      checks += 2;
      if (act8() !== '0) begin errors++; $display("FAIL rst_rel8 k=%0d got %h exp 0", k, act8()); end
      if (act4() !== '0) begin errors++; $display("FAIL rst_rel4 k=%0d got %h exp 0", k, act4()); end
    end
  endtask

  task automatic test_lock();
    int npv = 0, pv5 = -1;
    frz[0] = 0; frz[1] = 0; hi = '{3, 3}; lo = '{3, 3}; run[0] = 0; run[1] = 1;
    for (int k = 0; k < 80; k++) begin
      gen_adv();
      checks += 2;
      if (act8() !== exp8()) begin errors++; $display("FAIL lock_m8 @%0t got %h exp %h", $time, act8(), exp8()); end
      if (act4() !== exp4()) begin errors++; $display("FAIL lock_m4 @%0t got %h exp %h", $time, act4(), exp4()); end
      if (bus8.period_valid[0]) begin
        npv++;
        checks++;
        if (bus8.period[7:0] !== 8'd6) begin errors++; $display("FAIL lock_per got %0d exp 6", bus8.period[7:0]); end
        if (npv == 5) begin
          pv5 = k;
          checks++;
          if (bus8.locked[0] !== 1'b0) begin errors++; $display("FAIL lock_early got %b exp 0", bus8.locked[0]); end
        end
      end
      if (pv5 >= 0 && k == pv5 + 1) begin
        checks++;
        if (bus8.locked[0] !== 1'b1) begin errors++; $display("FAIL lock_set got %b exp 1", bus8.locked[0]); end
      end
    end
    checks++;
    if (npv < 5) begin errors++; $display("FAIL lock_pvcount got %0d exp >=5", npv); end
  endtask

  task automatic test_period_change();
    int n4 = 0, t1 = -1, t5 = -1;
    bit p;
    for (int k = 0; k < 20; k++) begin
      p = lvl[1];
      gen_adv();
      checks += 2;
      if (act8() !== exp8()) begin errors++; $display("FAIL pc_m8 @%0t got %h exp %h", $time, act8(), exp8()); end
      if (act4() !== exp4()) begin errors++; $display("FAIL pc_m4 @%0t got %h exp %h", $time, act4(), exp4()); end
      if (!p && lvl[1]) break;
    end
    checks++;
    if (bus8.locked[1] !== 1'b1) begin errors++; $display("FAIL pc_prelock got %b exp 1", bus8.locked[1]); end
    hi[1] = 2; lo[1] = 2;
    for (int k = 0; k < 60; k++) begin
      gen_adv();
      checks += 2;
      if (act8() !== exp8()) begin errors++; $display("FAIL pc_m8 @%0t got %h exp %h", $time, act8(), exp8()); end
      if (act4() !== exp4()) begin errors++; $display("FAIL pc_m4 @%0t got %h exp %h", $time, act4(), exp4()); end
      if (bus8.period_valid[1] && bus8.period[15:8] == 8'd4) begin
        n4++;
        if (n4 == 1) t1 = k;
        if (n4 == 5) begin
          t5 = k;
          checks++;
          if (bus8.locked[1] !== 1'b0) begin errors++; $display("FAIL pc_early got %b exp 0", bus8.locked[1]); end
        end
      end
      if (t1 >= 0 && k == t1 + 1) begin
        checks++;
        if (bus8.locked[1] !== 1'b0) begin errors++; $display("FAIL pc_drop got %b exp 0", bus8.locked[1]); end
      end
      if (t5 >= 0 && k == t5 + 1) begin
        checks++;
        if (bus8.locked[1] !== 1'b1) begin errors++; $display("FAIL pc_relock got %b exp 1", bus8.locked[1]); end
      end
    end
    checks++;
    if (t5 < 0) begin errors++; $display("FAIL pc_runs got %0d exp >=5", n4); end
  endtask

  task automatic test_timeout();
    int since = 0, nr = 0;
    bit seen = 0, fz = 0, got = 0, p;
    checks++;
    if (bus4.locked[0] !== 1'b1) begin errors++; $display("FAIL to_prelock got %b exp 1", bus4.locked[0]); end
    for (int k = 0; k < 60; k++) begin
      p = lvl[0];
      gen_adv();
      checks += 2;
      if (act8() !== exp8()) begin errors++; $display("FAIL to_m8 @%0t got %h exp %h", $time, act8(), exp8()); end
      if (act4() !== exp4()) begin errors++; $display("FAIL to_m4 @%0t got %h exp %h", $time, act4(), exp4()); end
      if (bus4.rise_pulse[0]) since = 0; else since++;
      if (!fz && p && !lvl[0]) begin frz[0] = 1; fz = 1; end
      if (!seen && bus4.timeout[0] === 1'b1) begin
        seen = 1;
        checks += 2;
        if (since != 15) begin errors++; $display("FAIL to_cnt got %0d exp 15", since); end
        if (bus4.locked[0] !== 1'b0) begin errors++; $display("FAIL to_unlock got %b exp 0", bus4.locked[0]); end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL to_seen got 0 exp 1"); end
    frz[0] = 0; run[0] = 0;
    for (int k = 0; k < 30; k++) begin
      gen_adv();
      checks += 2;
      if (act8() !== exp8()) begin errors++; $display("FAIL tr_m8 @%0t got %h exp %h", $time, act8(), exp8()); end
      if (act4() !== exp4()) begin errors++; $display("FAIL tr_m4 @%0t got %h exp %h", $time, act4(), exp4()); end
      if (bus4.rise_pulse[0]) nr++;
      if (!got && bus4.period_valid[0]) begin
        got = 1;
        checks += 3;
        if (nr != 2) begin errors++; $display("FAIL tr_rises got %0d exp 2", nr); end
        if (bus4.period[3:0] !== 4'd6) begin errors++; $display("FAIL tr_per got %0d exp 6", bus4.period[3:0]); end
        if (bus4.timeout[0] !== 1'b1) begin errors++; $display("FAIL tr_sticky got %b exp 1", bus4.timeout[0]); end
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL tr_restart got 0 exp 1"); end
  endtask

  task automatic test_reset_mid();
    frz[0] = 1; frz[1] = 1; rst = 1;
    gen_adv();
    checks += 2;
    if (act8() !== '0) begin errors++; $display("FAIL rm_clr8 got %h exp 0", act8()); end
    if (act4() !== '0) begin errors++; $display("FAIL rm_clr4 got %h exp 0", act4()); end
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      gen_adv();
      checks++;
      if ((bus8.rise_pulse | bus8.fall_pulse | bus4.rise_pulse | bus4.fall_pulse) !== 2'b00) begin
        errors++; $display("FAIL rm_spur got %b%b exp 00", bus8.rise_pulse, bus8.fall_pulse);
      end
    end
    frz[0] = 0; frz[1] = 0;
    for (int k = 0; k < 30; k++) begin
      gen_adv();
      checks += 2;
      if (act8() !== exp8()) begin errors++; $display("FAIL rm_m8 @%0t got %h exp %h", $time, act8(), exp8()); end
      if (act4() !== exp4()) begin errors++; $display("FAIL rm_m4 @%0t got %h exp %h", $time, act4(), exp4()); end
    end
  endtask

  task automatic test_max_period();
    int npv = 0;
    hi = '{7, 8}; lo = '{8, 8};
    for (int k = 0; k < 80; k++) begin
      gen_adv();
      checks += 2;
      if (act8() !== exp8()) begin errors++; $display("FAIL mx_m8 @%0t got %h exp %h", $time, act8(), exp8()); end
      if (act4() !== exp4()) begin errors++; $display("FAIL mx_m4 @%0t got %h exp %h", $time, act4(), exp4()); end
      if (bus4.period_valid[0]) begin
        npv++;
        if (npv >= 2) begin
          checks += 2;
          if (bus4.period[3:0] !== 4'd15) begin errors++; $display("FAIL mx_per got %0d exp 15", bus4.period[3:0]); end
          if (bus4.timeout[0] !== 1'b0) begin errors++; $display("FAIL mx_noto got %b exp 0", bus4.timeout[0]); end
        end
      end
    end
    checks += 2;
    if (npv < 3) begin errors++; $display("FAIL mx_pvcount got %0d exp >=3", npv); end
    if (bus4.timeout[1] !== 1'b1) begin errors++; $display("FAIL mx_to16 got %b exp 1", bus4.timeout[1]); end
  endtask

  task automatic test_fast();
    logic [1:0] prev_r = '0;
    hi = '{1, 1}; lo = '{1, 1};
    for (int k = 0; k < 40; k++) begin
      gen_adv();
      checks += 2;
      if (act8() !== exp8()) begin errors++; $display("FAIL fs_m8 @%0t got %h exp %h", $time, act8(), exp8()); end
      if (act4() !== exp4()) begin errors++; $display("FAIL fs_m4 @%0t got %h exp %h", $time, act4(), exp4()); end
      if (k >= 3) begin
        checks += 2;
        if ((bus8.rise_pulse ^ bus8.fall_pulse) !== 2'b11) begin
          errors++; $display("FAIL fs_excl got r=%b f=%b exp one each", bus8.rise_pulse, bus8.fall_pulse);
        end
        if (bus8.rise_pulse !== ~prev_r) begin
          errors++; $display("FAIL fs_alt got %b exp %b", bus8.rise_pulse, ~prev_r);
        end
      end
      if (k >= 10 && bus8.period_valid != 2'b00) begin
        checks++;
        if (bus8.period !== 16'h0202) begin errors++; $display("FAIL fs_per got %h exp 0202", bus8.period); end
      end
      prev_r = bus8.rise_pulse;
    end
    checks += 2;
    if (bus8.locked !== 2'b11) begin errors++; $display("FAIL fs_lock8 got %b exp 11", bus8.locked); end
    if (bus4.locked !== 2'b11) begin errors++; $display("FAIL fs_lock4 got %b exp 11", bus4.locked); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(39) == 0) begin
          hi[c] = int'($urandom_range(9, 1));
          lo[c] = int'($urandom_range(9, 1));
        end
        if (!frz[c] && $urandom_range(199) == 0) frz[c] = 1;
        else if (frz[c] && $urandom_range(29) == 0) frz[c] = 0;
        if ($urandom_range(299) == 0) begin lvl[c] = !lvl[c]; run[c] = 0; end
      end
      rst = ($urandom_range(499) == 0);
      gen_adv();
      checks += 2;
      if (act8() !== exp8()) begin errors++; $display("FAIL rnd_m8 @%0t got %h exp %h", $time, act8(), exp8()); end
      if (act4() !== exp4()) begin errors++; $display("FAIL rnd_m4 @%0t got %h exp %h", $time, act4(), exp4()); end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_period_change();
    test_timeout();
    test_reset_mid();
    test_max_period();
    test_fast();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

Per-channel monitor that sits directly downstream of the clock divider and consumes its divided-clock outputs (for example the divide-by-2 and divide-by-3 signals) as ordinary data sampled in the source clock domain. For each channel it produces single-cycle rise/fall strobes that downstream logic uses as clock enables. It also measures the divided period in source-clock cycles and asserts a lock flag once the period is stable. It lets the rest of the design stay single-clock and gives verification a self-check on divider behaviour.

## Interface
- N_CH, default 2: number of monitored divided-clock channels.
- CNT_W, default 8: width of the per-channel period counter and the period output.
- LOCK_COUNT, default 4: number of consecutive matching periods required to assert lock; legal range 1..15.

- clk  in  1: source clock, the same clock that drives the divider. One clock; every flop in this block is clocked on its rising edge.
- rst  in  1: synchronous, active-high reset.
- div_in  in  N_CH: divided-clock levels, already synchronous to clk. No synchronizer is required.
- rise_pulse  out  N_CH: one-cycle strobe per rising edge of div_in[i].
- fall_pulse  out  N_CH: one-cycle strobe per falling edge of div_in[i].
- period  out  N_CH*CNT_W: last measured period of channel i, in slice [i*CNT_W +: CNT_W].
- period_valid  out  N_CH: one-cycle strobe when period[i] updates.
- locked  out  N_CH: period of channel i is stable.
- timeout  out  N_CH: sticky flag; channel i saw no rising edge for 2^CNT_W-1 cycles.

## Operation
- Edge detect: div_q[i] holds div_in[i] from the previous cycle.
  - rise = div_in & ~div_q.
  - fall = ~div_in & div_q.
  - Strobes are registered.
- Reset behaviour:
  - While rst is high, div_q loads div_in, so no spurious edge appears on the first cycle after reset release.
  - All other state clears: rise_pulse, fall_pulse, period_valid, locked and timeout = 0; period = 0; cnt = 0; match_cnt = 0; FSM = IDLE.
- Per-channel FSM (states IDLE, FIRST, TRACK):
  - IDLE: cnt held at 0. On the first rise, go to FIRST and set cnt = 1.
  - FIRST: cnt increments each cycle.
    - On rise: period <= cnt, period_valid pulses, cnt <= 1, match_cnt <= 0, go to TRACK.
  - TRACK: cnt increments each cycle.
    - On rise, a new period is captured and period_valid pulses.
    - If the new period equals the previous one, match_cnt increments, saturating at LOCK_COUNT.
    - Otherwise match_cnt <= 0 and locked <= 0.
    - locked <= 1 when match_cnt reaches LOCK_COUNT.
- Timeout: in FIRST or TRACK, when cnt reaches 2^CNT_W-1 with no rise:
  - go to IDLE, set cnt = 0, clear locked and match_cnt, set timeout = 1.
  - period keeps its last value.
  - timeout stays set until rst.
- Simultaneous events: a rise on the same cycle cnt reaches the maximum counts as a rise, not a timeout, and period captures the maximum value.
- Channels are fully independent of each other.

## Timing
- Latency:
  - div_in changes after clk edge k.
  - rise_pulse/fall_pulse are high in the cycle following edge k+1, for exactly one cycle.
  - period and period_valid update on the same edge as rise_pulse.
  - locked updates one cycle after the period_valid that completes the match run.
- Period definition: the number of clk cycles between two consecutive rise_pulse assertions. For a square wave high for 3 cycles and low for 3 cycles, period = 6.
- Minimum supported period: 2, i.e. div_in toggling every cycle. At that rate rise and fall strobes alternate every cycle.
- Widths:
  - period is unsigned CNT_W.
  - match_cnt is 4 bits.
  - The period comparison is exact equality.

## Structure
- Package div_mon_pkg:
  - state enum {IDLE, FIRST, TRACK}.
  - MATCH_W = 4.
- Sub-module div_chan_monitor: one channel, containing edge detect, cnt, FSM, match_cnt, period register and flags.
- Top level: generate-loop of N_CH instances of div_chan_monitor plus concatenation of the period slices.

## Test plan
- Reset release with div_in = 2'b11 held high: no rise_pulse for 10 cycles; all outputs 0.
- Channel 0 toggling every 3 cycles: period[7:0] = 6 on every period_valid; locked[0] = 1 one cycle after the 5th period_valid (LOCK_COUNT = 4).
- Channel 1 period changes from 6 to 4 after lock: locked[1] drops one cycle after the first period = 4 capture, then reasserts after 4 further matches.
- Channel 0 stuck low after lock with CNT_W = 4: timeout[0] = 1 and locked[0] = 0 at cnt = 15; FSM returns to IDLE; the next two rises restart measurement.
- rst asserted mid-TRACK: next cycle all outputs 0; after release, measurement restarts from IDLE with no spurious strobe.
- div_in toggling every cycle: rise and fall strobes alternate each cycle; period = 2; lock is achieved.
